wb_arbiter: RTL and testbench

- Round-robin Wishbone arbiter letting NM bus masters (CPU plus DMA/blitter-style requesters) share the single master port of WB_intercon.
- Sits between the masters and the intercon's master_* side; one transaction owns the bus from grant until ACK.
- Guarantees fairness: no master waits more than NM-1 transactions.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_arbiter_rr_pick.sv | 32 +++
 rtl/wb_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: state encoding,
// default bus widths and the read value returned with a timeout error.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Read data presented to the owner when its transaction times out.
    localparam logic [31:0] TO_RDATA = 32'h0000_0000;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester scanning last+1, last+2, ...
// modulo NM.
module rr_pick #(
    parameter int NM = 2,
    parameter int IW = 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    int          j;
    logic [IW-1:0] jj;

    // Scan from farthest to nearest so the nearest hit after 'last' is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int k = NM; k >= 1; k--) begin
            j  = (int'(last) + k) % NM;
            jj = IW'(j);
            if (req[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among NM masters.
// Optional bus timeout with error response is enabled by WB_ARB_TIMEOUT_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM-1:0]    m_STB,
    input  logic [NM-1:0]    m_WE,
    input  logic [NM*AW-1:0] m_ADDR,
    input  logic [NM*DW-1:0] m_DAT_O,
    output logic [DW-1:0]    m_DAT_I,
    output logic [NM-1:0]    m_ACK,
    output logic [NM-1:0]    grant,
    output logic             busy,
    output logic             err,
    output logic             s_STB,
    output logic             s_WE,
    output logic [AW-1:0]    s_ADDR,
    output logic [DW-1:0]    s_DAT_O,
    input  logic [DW-1:0]    s_DAT_I,
    input  logic             s_ACK
);

    localparam int IW = (NM > 2) ? 2 : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;
    logic          found;
    logic [IW-1:0] pick;
    logic          to_hit;

    rr_pick #(
        .NM (NM),
        .IW (IW)
    ) u_pick (
        .req   (m_STB),
        .last  (last_q),
        .found (found),
        .idx   (pick)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt_q, tcnt_d;

    // Error response fires on the BUSY cycle where the counter reaches TIMEOUT;
    // a real ACK in that cycle takes precedence.
    assign to_hit = (state_q == ST_BUSY) && m_STB[gnt_q] && !s_ACK &&
                    (tcnt_q == TW'(TIMEOUT));

    always_comb begin
        tcnt_d = '0;
        if (state_q == ST_BUSY && !s_ACK)
            tcnt_d = tcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            tcnt_q <= '0;
        else
            tcnt_q <= tcnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NM - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick;
                end
            end
            ST_BUSY: begin
                // A dropped strobe aborts the transaction even if ACK arrives together.
                if (!m_STB[gnt_q]) begin
                    state_d = ST_IDLE;
                end else if (s_ACK || to_hit) begin
                    state_d = ST_RELEASE;
                    last_d  = gnt_q;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_DAT_I = s_DAT_I;
        m_ACK   = '0;
        grant   = '0;
        busy    = 1'b0;
        err     = 1'b0;
        s_STB   = 1'b0;
        s_WE    = 1'b0;
        s_ADDR  = '0;
        s_DAT_O = '0;
        if (state_q == ST_BUSY) begin
            grant[gnt_q] = 1'b1;
            busy         = 1'b1;
            s_STB        = m_STB[gnt_q] & ~to_hit;
            s_WE         = m_WE[gnt_q];
            s_ADDR       = m_ADDR[int'(gnt_q)*AW +: AW];
            s_DAT_O      = m_DAT_O[int'(gnt_q)*DW +: DW];
            m_ACK[gnt_q] = m_STB[gnt_q] & (s_ACK | to_hit);
            err          = to_hit;
            if (to_hit)
                m_DAT_I = DW'(TO_RDATA);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a cycle-level reference model and literal checks.
module tb_wb_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic [NM-1:0]    m_STB   = '0;
    logic [NM-1:0]    m_WE    = '0;
    logic [NM*AW-1:0] m_ADDR  = '0;
    logic [NM*DW-1:0] m_DAT_O = '0;
    logic [DW-1:0]    m_DAT_I;
    logic [NM-1:0]    m_ACK;
    logic [NM-1:0]    grant;
    logic             busy;
    logic             err;
    logic             s_STB;
    logic             s_WE;
    logic [AW-1:0]    s_ADDR;
    logic [DW-1:0]    s_DAT_O;
    logic [DW-1:0]    s_DAT_I = 32'hC0DE_0001;
    logic             s_ACK   = 1'b0;

    wb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m_STB(m_STB), .m_WE(m_WE), .m_ADDR(m_ADDR), .m_DAT_O(m_DAT_O),
        .m_DAT_I(m_DAT_I), .m_ACK(m_ACK), .grant(grant), .busy(busy), .err(err),
        .s_STB(s_STB), .s_WE(s_WE), .s_ADDR(s_ADDR), .s_DAT_O(s_DAT_O),
        .s_DAT_I(s_DAT_I), .s_ACK(s_ACK)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: who owns the bus, who was served last, how long the owner has held it.
    int md  = 0;        // 0 free, 1 owned, 2 cooldown after a completed transfer
    int own = 0;
    int lst = NM - 1;
    int bc  = 0;        // BUSY cycles so far for the current owner (1 on the first)
    bit started = 1'b0;

    function automatic bit bitof(input logic [NM-1:0] v, input int j);
        return |(v & (NM'(1) << j));
    endfunction

    function automatic bit m_to_hit();
        return TO_EN && md == 1 && bitof(m_STB, own) && !s_ACK && bc == TO + 1;
    endfunction

    function automatic int m_pick();
        for (int k = 1; k <= NM; k++)
            if (bitof(m_STB, (lst + k) % NM)) return (lst + k) % NM;
        return -1;
    endfunction

    always @(posedge clk) begin : mdl
        bit hit;
        int p;
        hit = m_to_hit();
        started = 1'b1;
        if (!reset) begin
            md = 0; lst = NM - 1; bc = 0;
        end else begin
            case (md)
                0: begin
                    p = m_pick();
                    if (p >= 0) begin md = 1; own = p; bc = 1; end
                end
                1: begin
                    if (!bitof(m_STB, own)) md = 0;
                    else if (s_ACK || hit) begin lst = own; md = 2; end
                    else bc++;
                end
                default: md = 0;
            endcase
        end
    end

    always @(negedge clk) begin : cmp
        logic [NM-1:0] eg, ea;
        bit hit, ob, live;
        if (started) begin
            hit  = m_to_hit();
            ob   = (md == 1);
            live = ob && bitof(m_STB, own);
            eg   = ob ? (NM'(1) << own) : '0;
            ea   = (live && (s_ACK || hit)) ? eg : '0;
            chk("grant",   grant,   eg);
            chk("busy",    busy,    ob);
            chk("s_STB",   s_STB,   live && !hit);
            chk("s_WE",    s_WE,    ob && bitof(m_WE, own));
            chk("s_ADDR",  s_ADDR,  ob ? m_ADDR[own*AW +: AW] : '0);
            chk("s_DAT_O", s_DAT_O, ob ? m_DAT_O[own*DW +: DW] : '0);
            chk("m_ACK",   m_ACK,   ea);
            chk("err",     err,     hit);
            chk("m_DAT_I", m_DAT_I, hit ? '0 : s_DAT_I);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [NM-1:0] alt_seq [7];

    initial begin
        alt_seq = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};

        // Reset state
        tick(); tick(); #2;
        chk("rst_grant", grant, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_sstb",  s_STB, 0);
        chk("rst_mack",  m_ACK, 0);
        chk("rst_err",   err,   0);
        reset = 1'b1;

        // Single master write
        m_ADDR[0 +: AW]  = 32'h10;
        m_DAT_O[0 +: DW] = 32'hA5;
        m_WE  = 2'b01;
        m_STB = 2'b01;
        tick(); #2;
        chk("w_grant", grant,   2'b01);
        chk("w_sstb",  s_STB,   1);
        chk("w_addr",  s_ADDR,  32'h10);
        chk("w_dat",   s_DAT_O, 32'hA5);
        chk("w_we",    s_WE,    1);
        tick();
        tick(); s_ACK = 1'b1; s_DAT_I = 32'h1234_5678; #2;
        chk("w_mack",  m_ACK,   2'b01);
        tick(); s_ACK = 1'b0; m_STB = '0; m_WE = '0; #2;
        chk("w_rel_grant", grant, 0);
        chk("w_rel_busy",  busy,  0);
        tick(); #2;
        chk("w_idle_busy", busy, 0);

        // Both masters hold STB, slave acks every cycle: strict alternation
        reset = 1'b0;
        tick(); reset = 1'b1; m_STB = 2'b11; s_ACK = 1'b1;
        m_ADDR[AW +: AW] = 32'h20; m_DAT_O[DW +: DW] = 32'h5A;
        for (int i = 0; i < 7; i++) begin
            tick(); #2;
            chk($sformatf("alt_grant%0d", i), grant, alt_seq[i]);
        end
        s_ACK = 1'b0; m_STB = '0;
        tick(); tick();

        // Master 1 owns the bus, master 0 joins and is served right after release
        m_STB = 2'b10;
        tick(); #2;
        chk("ns_grant1", grant, 2'b10);
        m_STB = 2'b11;
        tick(); #2;
        chk("ns_hold", grant, 2'b10);
        tick(); s_ACK = 1'b1; #2;
        chk("ns_mack1", m_ACK, 2'b10);
        tick(); s_ACK = 1'b0; m_STB = 2'b01; #2;
        chk("ns_rel", grant, 0);
        tick(); #2;
        chk("ns_idle", grant, 0);
        tick(); #2;
        chk("ns_grant0", grant, 2'b01);
        s_ACK = 1'b1;
        tick(); s_ACK = 1'b0; m_STB = '0;
        tick();

        // Abort keeps 'last': master 0 still wins after it drops STB
        reset = 1'b0;
        tick(); reset = 1'b1; m_STB = 2'b01;
        tick(); #2;
        chk("ab_grant", grant, 2'b01);
        tick(); m_STB = 2'b00; #2;
        chk("ab_mack", m_ACK, 0);
        chk("ab_sstb", s_STB, 0);
        chk("ab_busy", busy,  1);
        tick(); #2;
        chk("ab_idle", busy, 0);
        m_STB = 2'b11;
        tick(); #2;
        chk("ab_regrant", grant, 2'b01);
        // ACK together with a dropped strobe is discarded and returns straight to IDLE
        m_STB = 2'b10; s_ACK = 1'b1; #2;
        chk("abk_mack", m_ACK, 0);
        tick(); s_ACK = 1'b0; #2;
        chk("abk_idle", busy, 0);
        tick(); #2;
        chk("abk_grant1", grant, 2'b10);
        s_ACK = 1'b1;
        tick(); s_ACK = 1'b0; m_STB = '0;
        tick(); tick();

        // Reset in the middle of a transfer
        m_STB = 2'b01;
        tick(); s_ACK = 1'b1;
        tick(); s_ACK = 1'b0; m_STB = '0;
        tick(); m_STB = 2'b01;
        tick(); #2;
        chk("rb_sstb_pre", s_STB, 1);
        reset = 1'b0;
        tick(); #2;
        chk("rb_sstb",  s_STB, 0);
        chk("rb_grant", grant, 0);
        chk("rb_busy",  busy,  0);
        reset = 1'b1; m_STB = 2'b11;
        tick(); #2;
        chk("rb_regrant", grant, 2'b01);
        m_STB = '0;
        tick(); tick();

        // Slave never acknowledges
        s_DAT_I = 32'hDEAD_BEEF;
        m_STB = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            tick(); #2;
`ifdef WB_ARB_TIMEOUT_EN
            if (c == TO + 1) begin
                chk("to_err",  err,     1);
                chk("to_mack", m_ACK,   2'b01);
                chk("to_data", m_DAT_I, 0);
                m_STB = '0;
            end else if (c == TO + 2) begin
                chk("to_rel", busy, 0);
            end else if (c <= TO) begin
                chk($sformatf("to_wait%0d", c), err, 0);
            end
`else
            chk($sformatf("nt_busy%0d", c), busy, 1);
            chk($sformatf("nt_err%0d", c),  err,  0);
`endif
        end
        m_STB = '0;
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
